// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter and two-phase instruction fetch sequencer (optional skip: FETCH_SEQ_SKIP_EN)
module fetch_sequencer #(
  parameter int PC_W = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load_pc,
  input  logic [PC_W-1:0] load_addr,
`ifdef FETCH_SEQ_SKIP_EN
  input  logic            skip,
`endif
  input  logic [7:0]      program_byte,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      instr,
  output logic [3:0]      oprnd,
  output logic            phase,
  output logic            fetch_valid
);

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } phase_t;

  phase_t          phase_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [3:0]      instr_q;
  logic [3:0]      oprnd_q;
  logic            fetch_valid_q;

  // Next program counter: increment after a fetch, optional jump or skip in EXECUTE.
  always_comb begin
    pc_d = pc_q;
    if (phase_q == FETCH) begin
      pc_d = pc_q + PC_W'(1);
    end else if (load_pc) begin
      pc_d = load_addr;
`ifdef FETCH_SEQ_SKIP_EN
    end else if (skip) begin
      pc_d = pc_q + PC_W'(1);
`endif
    end
  end

  // Sequencer state, fetch latch and strobe; everything holds while enable is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= FETCH;
      pc_q          <= '0;
      instr_q       <= '0;
      oprnd_q       <= '0;
      fetch_valid_q <= 1'b0;
    end else if (enable) begin
      pc_q <= pc_d;
      case (phase_q)
        FETCH: begin
          instr_q       <= program_byte[7:4];
          oprnd_q       <= program_byte[3:0];
          fetch_valid_q <= 1'b1;
          phase_q       <= EXECUTE;
        end
        default: begin
          fetch_valid_q <= 1'b0;
          phase_q       <= FETCH;
        end
      endcase
    end else begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign oprnd       = oprnd_q;
  assign phase       = phase_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

  localparam int PC_W = 12;

  logic            clock;
  logic            reset;
  logic            enable;
  logic            load_pc;
  logic [PC_W-1:0] load_addr;
  logic            skip;
  logic [7:0]      program_byte;
  logic [PC_W-1:0] pc;
  logic [3:0]      instr;
  logic [3:0]      oprnd;
  logic            phase;
  logic            fetch_valid;

  logic [7:0] mem [0:(1<<PC_W)-1];

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [3:0]      instr;
    logic [3:0]      oprnd;
    logic            phase;
    logic            fv;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_bad;
  bit   stim_done;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .load_pc      (load_pc),
    .load_addr    (load_addr),
`ifdef FETCH_SEQ_SKIP_EN
    .skip         (skip),
`endif
    .program_byte (program_byte),
    .pc           (pc),
    .instr        (instr),
    .oprnd        (oprnd),
    .phase        (phase),
    .fetch_valid  (fetch_valid)
  );

  assign program_byte = mem[pc];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs and record the state expected after the next edge.
  task automatic step(input logic rst, input logic en, input logic ld,
                      input logic [PC_W-1:0] addr, input logic sk,
                      input logic [PC_W-1:0] e_pc, input logic [3:0] e_i,
                      input logic [3:0] e_o, input logic e_ph, input logic e_fv,
                      input string name);
    exp_t e;
    @(posedge clock);
    #2;
    reset     = rst;
    enable    = en;
    load_pc   = ld;
    load_addr = addr;
    skip      = sk;
    e.pc = e_pc; e.instr = e_i; e.oprnd = e_o; e.phase = e_ph; e.fv = e_fv; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT state against each queued expectation just after the edge.
  initial begin
    exp_t e;
    n_vec = 0;
    n_bad = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (pc !== e.pc || instr !== e.instr || oprnd !== e.oprnd ||
            phase !== e.phase || fetch_valid !== e.fv) begin
          n_bad++;
          $display("FAIL %s: got pc=%03h instr=%h oprnd=%h phase=%b fv=%b, want pc=%03h instr=%h oprnd=%h phase=%b fv=%b",
                   e.name, pc, instr, oprnd, phase, fetch_valid,
                   e.pc, e.instr, e.oprnd, e.phase, e.fv);
        end
      end
    end
  end

  initial begin
    stim_done = 1'b0;
    for (int a = 0; a < (1 << PC_W); a++) mem[a] = 8'h00;
    mem[12'h000] = 8'h3A; mem[12'h001] = 8'h51; mem[12'h002] = 8'hF0;
    mem[12'h003] = 8'h12; mem[12'h004] = 8'h34;
    mem[12'h123] = 8'h9C; mem[12'h124] = 8'h7E; mem[12'h125] = 8'hA5;
    mem[12'h126] = 8'hB6; mem[12'h127] = 8'hC7; mem[12'hFFF] = 8'hD8;
    mem[12'h455] = 8'hE9; mem[12'h00F] = 8'h4B; mem[12'h011] = 8'h6D;
    reset = 1'b1; enable = 1'b0; load_pc = 1'b0; load_addr = '0; skip = 1'b0;

    //    rst en ld addr    sk  pc      i     o     ph fv
    step(1, 1, 1, 12'h7AA, 0, 12'h000, 4'h0, 4'h0, 0, 0, "reset_c1");
    step(1, 0, 0, 12'h000, 0, 12'h000, 4'h0, 4'h0, 0, 0, "reset_c2");
    step(0, 1, 0, 12'h000, 0, 12'h001, 4'h3, 4'hA, 1, 1, "run_fetch0");
    step(0, 1, 0, 12'h000, 0, 12'h001, 4'h3, 4'hA, 0, 0, "run_exec0");
    step(0, 1, 0, 12'h000, 0, 12'h002, 4'h5, 4'h1, 1, 1, "run_fetch1");
    step(0, 1, 0, 12'h000, 0, 12'h002, 4'h5, 4'h1, 0, 0, "run_exec1");
    step(0, 1, 0, 12'h000, 0, 12'h003, 4'hF, 4'h0, 1, 1, "run_fetch2");
    step(0, 1, 0, 12'h000, 0, 12'h003, 4'hF, 4'h0, 0, 0, "run_exec2");
    step(0, 1, 0, 12'h000, 0, 12'h004, 4'h1, 4'h2, 1, 1, "run_fetch3");
    step(0, 1, 0, 12'h000, 0, 12'h004, 4'h1, 4'h2, 0, 0, "run_exec3");
    step(0, 1, 0, 12'h000, 0, 12'h005, 4'h3, 4'h4, 1, 1, "run_fetch4");
    step(0, 1, 1, 12'h123, 0, 12'h123, 4'h3, 4'h4, 0, 0, "jump_exec");
    step(0, 1, 0, 12'h000, 0, 12'h124, 4'h9, 4'hC, 1, 1, "jump_fetch");
    step(0, 1, 0, 12'h000, 0, 12'h124, 4'h9, 4'hC, 0, 0, "jump_exec2");
    step(0, 1, 1, 12'h7FF, 0, 12'h125, 4'h7, 4'hE, 1, 1, "ign_load_fetch");
    step(0, 1, 0, 12'h000, 0, 12'h125, 4'h7, 4'hE, 0, 0, "ign_load_exec");
    step(0, 1, 0, 12'h000, 0, 12'h126, 4'hA, 4'h5, 1, 1, "pre_stall_fetch");
    step(0, 0, 1, 12'h300, 0, 12'h126, 4'hA, 4'h5, 1, 0, "stall_c1");
    step(0, 0, 1, 12'h300, 0, 12'h126, 4'hA, 4'h5, 1, 0, "stall_c2");
    step(0, 0, 0, 12'h000, 0, 12'h126, 4'hA, 4'h5, 1, 0, "stall_c3");
    step(0, 1, 0, 12'h000, 0, 12'h126, 4'hA, 4'h5, 0, 0, "resume_exec");
    step(0, 1, 0, 12'h000, 0, 12'h127, 4'hB, 4'h6, 1, 1, "resume_fetch");
    step(0, 1, 0, 12'h000, 0, 12'h127, 4'hB, 4'h6, 0, 0, "resume_exec2");
    step(0, 1, 0, 12'h000, 0, 12'h128, 4'hC, 4'h7, 1, 1, "pre_wrap_fetch");
    step(0, 1, 1, 12'hFFF, 0, 12'hFFF, 4'hC, 4'h7, 0, 0, "jump_to_fff");
    step(0, 1, 0, 12'h000, 0, 12'h000, 4'hD, 4'h8, 1, 1, "wrap_fetch");
    step(0, 1, 0, 12'h000, 0, 12'h000, 4'hD, 4'h8, 0, 0, "wrap_exec");
    step(0, 1, 0, 12'h000, 0, 12'h001, 4'h3, 4'hA, 1, 1, "post_wrap_fetch");
    step(0, 1, 1, 12'h455, 0, 12'h455, 4'h3, 4'hA, 0, 0, "jump_455");
    step(0, 1, 0, 12'h000, 0, 12'h456, 4'hE, 4'h9, 1, 1, "fetch_455");
    step(1, 1, 1, 12'h222, 0, 12'h000, 4'h0, 4'h0, 0, 0, "midrun_reset");
    step(0, 1, 0, 12'h000, 0, 12'h001, 4'h3, 4'hA, 1, 1, "post_reset_fetch");
`ifdef FETCH_SEQ_SKIP_EN
    step(0, 1, 1, 12'h00F, 0, 12'h00F, 4'h3, 4'hA, 0, 0, "jump_00f");
    step(0, 1, 0, 12'h000, 0, 12'h010, 4'h4, 4'hB, 1, 1, "fetch_00f");
    step(0, 1, 0, 12'h000, 1, 12'h011, 4'h4, 4'hB, 0, 0, "skip_exec");
    step(0, 1, 0, 12'h000, 1, 12'h012, 4'h6, 4'hD, 1, 1, "skip_ign_fetch");
    step(0, 1, 1, 12'h200, 1, 12'h200, 4'h6, 4'hD, 0, 0, "skip_vs_load");
`else
    step(0, 1, 0, 12'h000, 1, 12'h001, 4'h3, 4'hA, 0, 0, "no_skip_exec");
`endif
    stim_done = 1'b1;

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
    #3;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and instruction-fetch stage of the simple microprocessor.
- Drives the program memory address and latches each fetched byte into a 4-bit opcode and a 4-bit operand.
- Sits directly upstream of the datapath selectors: `oprnd` feeds the 4-bit 2:1 operand selector, `instr` feeds the decoder, and `phase` times the datapath.
- A two-phase FETCH/EXECUTE sequencer drives all of this, with a jump load in EXECUTE.

Parameters:
- PC_W, 12, width of the program counter and program memory address.

Ports:
- `clock` in 1 — single system clock; all state updates on the rising edge.
- `reset` in 1 — synchronous, active-high reset.
- `enable` in 1 — advance the sequencer this cycle; when low, all state holds.
- `load_pc` in 1 — jump request, sampled in EXECUTE only.
- `load_addr` in PC_W — jump target.
- `program_byte` in 8 — program memory read data for address `pc`; combinational memory.
- `pc` out PC_W — current program counter / memory address.
- `instr` out 4 — latched opcode, `program_byte[7:4]`.
- `oprnd` out 4 — latched operand, `program_byte[3:0]`.
- `phase` out 1 — 0 = FETCH, 1 = EXECUTE.
- `fetch_valid` out 1 — one-cycle pulse: `instr`/`oprnd` updated on the previous edge.

Behaviour:
- Reset, checked at the clock edge while `reset`=1: `pc`=0, `instr`=0, `oprnd`=0, `phase`=FETCH, `fetch_valid`=0.
- Reset overrides `enable`, `load_pc` and mid-operation state. The first cycle after reset is FETCH with `pc`=0.
- `enable`=0: `pc`, `instr`, `oprnd` and `phase` hold; `fetch_valid`=0.
- FETCH with `enable`=1, on the edge:
  - `{instr,oprnd}` <= `program_byte`;
  - `pc` <= `pc`+1, modulo 2^PC_W;
  - `phase` <= EXECUTE;
  - `fetch_valid` <= 1.
- EXECUTE with `enable`=1, on the edge:
  - `load_pc`=1: `pc` <= `load_addr`; otherwise `pc` holds;
  - `phase` <= FETCH;
  - `fetch_valid` <= 0;
  - `instr`/`oprnd` hold.
- `load_pc` in FETCH: ignored, no effect.
- `load_pc` while `enable`=0: ignored.
- Wrap-around: `pc` = 2^PC_W-1 in FETCH goes to 0; no flag, no stall.
- Latency:
  - `program_byte` presented during FETCH is visible on `instr`/`oprnd` one cycle later, in EXECUTE.
  - A jump takes effect on the next FETCH; there are no delay slots.
- `fetch_valid` is 1 for exactly one cycle per completed FETCH. It is 0 in every other cycle, including stalls.
- FSM has exactly 2 states. An illegal encoding is impossible by construction; `phase` is a single flop.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: `FETCH_SEQ_SKIP_EN`.
- When defined, adds input `skip` (1 bit), sampled in EXECUTE with `enable`=1:
  - `skip`=1 and `load_pc`=0: `pc` <= `pc`+1, modulo 2^PC_W, skipping the next instruction;
  - `load_pc`=1 has priority over `skip`;
  - `skip` is ignored in FETCH and when `enable`=0.
- When undefined: the `skip` port does not exist, and EXECUTE behaviour is exactly as in Behaviour.

Test Plan:
- Reset then run: `reset`=1 for 2 cycles, `enable`=1, memory bytes 0x3A,0x51,0xF0 at addresses 0..2.
  - After 6 cycles, `pc` sequence is 0,1,1,2,2,3.
  - `{instr,oprnd}` = 3/A, 5/1, F/0, each appearing in EXECUTE.
  - `fetch_valid` is high in cycles 2, 4, 6 only.
- Jump: in EXECUTE with `pc`=0x005, `load_pc`=1, `load_addr`=0x123.
  - Next FETCH has `pc`=0x123; the following EXECUTE has `pc`=0x124.
- Ignored load: `load_pc`=1, `load_addr`=0x7FF held during FETCH only.
  - `pc` increments normally and no jump occurs.
- Stall: `enable`=0 for 3 cycles mid-EXECUTE.
  - `pc`, `phase`, `instr` and `oprnd` are unchanged; `fetch_valid`=0 throughout.
  - Resuming gives a normal FETCH.
- Wrap and mid-run reset:
  - `pc`=0xFFF in FETCH goes to `pc`=0x000.
  - `reset` pulsed in EXECUTE with `pc`=0x456 gives `pc`=0, `phase`=FETCH, `instr`=`oprnd`=0 next cycle.
- With `FETCH_SEQ_SKIP_EN`:
  - EXECUTE at `pc`=0x010 with `skip`=1 goes to `pc`=0x011 for the next FETCH.
  - `skip`=1 with `load_pc`=1, `load_addr`=0x200 goes to `pc`=0x200.
